// File: rtl/adder_measure_ctrl.sv
// Sequencer for one instrumented-adder delay measurement (ring-oscillator edge counter).
// Latency: counting the cycle start is presented in as cycle 1, done is high in cycle S+max(W,1)+6.
// Backpressure: none; start is honoured only in IDLE, abort returns to IDLE from any state.
//
// Ports
//   wb_clk_i            system clock, the only clock
//   wb_rst_i            synchronous reset, active-high
//   start               request a measurement (sampled only in IDLE)
//   abort               return to IDLE from any state; wins over start
//   cont                continuous re-trigger from DONE (CONTINUOUS_EN builds only)
//   a_in, b_in          adder operands, latched on an accepted start
//   settle              settle cycles before the ring is enabled, latched at start
//   window              ring-enable window in cycles, latched at start (0 behaves as 1)
//   ring_in             ring oscillator tap, asynchronous to wb_clk_i
//   adder_a, adder_b    latched operands driven to the adder under test
//   ring_en             ring oscillator enable (high only in RUN)
//   count, overflow     edge count of the last/current measurement, saturation flag
//   busy, done          measurement in progress, result valid (sticky)
//
// Build option: define CONTINUOUS_EN to let DONE re-trigger straight into SETUP while
// cont is high. Without it, cont is ignored and DONE always returns to IDLE.

module adder_measure_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic             abort,
  input  logic             cont,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [7:0]       settle,
  input  logic [WIN_W-1:0] window,
  input  logic             ring_in,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic             ring_en,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // One down-counter serves both the settle and the window phases, so it must
  // be wide enough for whichever of the two is wider.
  localparam int TMR_W = (WIN_W > 8) ? WIN_W : 8;

  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
  // DRAIN lasts three cycles: two for the synchronizer plus one for the edge
  // detector, so an edge that entered the flops on the last RUN cycle is counted.
  localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'(2);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [WIN_W-1:0] WIN_ONE    = WIN_W'(1);

  logic [2:0]       state;
  logic [7:0]       settle_q;
  logic [WIN_W-1:0] window_q;
  logic [TMR_W-1:0] timer;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             done_q;

  logic             ring_s1;
  logic             ring_s2;
  logic             ring_s3;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;

  logic             accept;
  logic             retrigger;
  logic             count_en;
  logic             ring_rise;
  logic [WIN_W-1:0] win_eff;
  logic [TMR_W-1:0] run_load;
  logic [TMR_W-1:0] settle_load;

  // ---------------------------------------------------------------------------
  // Control decodes
  // ---------------------------------------------------------------------------

  // abort beats start even in IDLE, so a simultaneous pair never starts anything.
  assign accept = (state == ST_IDLE) && start && !abort;

`ifdef CONTINUOUS_EN
  assign retrigger = (state == ST_DONE) && cont && !abort;
`else
  assign retrigger = 1'b0;
  logic unused_cont;
  assign unused_cont = cont;
`endif

  // A zero window still opens the ring for a single cycle.
  assign win_eff     = (window_q == '0) ? WIN_ONE : window_q;
  assign run_load    = TMR_W'(win_eff) - TMR_ONE;
  assign settle_load = TMR_W'(settle_q) - TMR_ONE;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      settle_q <= '0;
      window_q <= '0;
      timer    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      done_q   <= 1'b0;
    end else if (abort) begin
      // Operands, count and overflow deliberately hold their values.
      state  <= ST_IDLE;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_SETUP;
            a_q      <= a_in;
            b_q      <= b_in;
            settle_q <= settle;
            window_q <= window;
            done_q   <= 1'b0;
          end
        end

        ST_SETUP: begin
          // Operands are already on the adder; settle=0 skips straight to RUN.
          if (settle_q == '0) begin
            state <= ST_RUN;
            timer <= run_load;
          end else begin
            state <= ST_SETTLE;
            timer <= settle_load;
          end
        end

        ST_SETTLE: begin
          if (timer == '0) begin
            state <= ST_RUN;
            timer <= run_load;
          end else begin
            timer <= timer - TMR_ONE;
          end
        end

        ST_RUN: begin
          if (timer == '0) begin
            state <= ST_DRAIN;
            timer <= DRAIN_LOAD;
          end else begin
            timer <= timer - TMR_ONE;
          end
        end

        ST_DRAIN: begin
          if (timer == '0) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end else begin
            timer <= timer - TMR_ONE;
          end
        end

        ST_DONE: begin
          if (retrigger) begin
            // Back-to-back pass: fresh operands, same settle/window, and done
            // collapses to a one-cycle pulse.
            state  <= ST_SETUP;
            a_q    <= a_in;
            b_q    <= b_in;
            done_q <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Ring tap synchronizer, rising-edge detect and saturating edge counter.
  // One rising edge is resolvable per two clocks; faster rings alias.
  // ---------------------------------------------------------------------------
  assign ring_rise = ring_s2 && !ring_s3;
  assign count_en  = (state == ST_RUN) || (state == ST_DRAIN);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ring_s1 <= 1'b0;
      ring_s2 <= 1'b0;
      ring_s3 <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ring_s1 <= ring_in;
      ring_s2 <= ring_s1;
      ring_s3 <= ring_s2;
      if (accept || retrigger) begin
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else if (count_en && ring_rise) begin
        // At all-ones the count holds; the lost edge is what flags overflow.
        if (&count_q) begin
          ovf_q <= 1'b1;
        end else begin
          count_q <= count_q + CNT_ONE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign adder_a  = a_q;
  assign adder_b  = b_q;
  assign ring_en  = (state == ST_RUN);
  assign busy     = (state == ST_SETUP) || (state == ST_SETTLE) ||
                    (state == ST_RUN)   || (state == ST_DRAIN);
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_adder_measure_ctrl.sv
// Self-checking bench for adder_measure_ctrl: scoreboard of expected results per measurement.
// A stimulus thread issues measurements and a monitor thread checks each done rising edge.
// The ring model toggles only while ring_en is high and parks low otherwise.

module tb_adder_measure_ctrl;

  localparam int WIDTH   = 8;
  localparam int CNT_W   = 5;
  localparam int WIN_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic             cont;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [7:0]       settle;
  logic [WIN_W-1:0] window;
  logic             ring_in;
  logic [WIDTH-1:0] adder_a;
  logic [WIDTH-1:0] adder_b;
  logic             ring_en;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  adder_measure_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .start    (start),
    .abort    (abort),
    .cont     (cont),
    .a_in     (a_in),
    .b_in     (b_in),
    .settle   (settle),
    .window   (window),
    .ring_in  (ring_in),
    .adder_a  (adder_a),
    .adder_b  (adder_b),
    .ring_en  (ring_en),
    .count    (count),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    time t_issue;  // negedge at which start was raised (cycle 1)
    int  lat;      // cycle number in which done must first appear
    int  ren;      // cycles ring_en must be high
    int  a;
    int  b;
    int  cnt;
    int  ov;
  } exp_t;

  exp_t sb[$];
  bit   tog_q[$];     // per enabled cycle: does the ring toggle?
  int   n_checks  = 0;
  int   n_pass    = 0;
  bit   ring_auto = 1'b0;
  bit   cont_mode = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Ring oscillator model: runs only while enabled, stops low otherwise.
  initial begin
    forever begin
      @(negedge clk);
      if (ring_auto) begin
        if (ring_en) begin
          if (tog_q.size() > 0) begin
            if (tog_q.pop_front()) ring_in = ~ring_in;
          end
        end else begin
          ring_in = 1'b0;
        end
      end
    end
  end

  // Monitor: compares each completed measurement against the scoreboard.
  initial begin : monitor
    bit   done_p;
    bit   busy_p;
    int   ren;
    exp_t e;
    done_p = 1'b0;
    busy_p = 1'b0;
    ren    = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy && !busy_p) ren = 0;
        if (ring_en) ren++;
        if (done && !done_p && !cont_mode) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            check("latency",     int'(($time - e.t_issue) / 10) + 1, e.lat);
            check("ring_en_len", ren, e.ren);
            check("adder_a",     int'(adder_a), e.a);
            check("adder_b",     int'(adder_b), e.b);
            check("count",       int'(count), e.cnt);
            check("overflow",    int'(overflow), e.ov);
            check("busy_in_done", int'(busy), 0);
          end
        end
      end
      done_p = done;
      busy_p = busy;
    end
  end

  // Program the operands/config and the ring pattern; returns the expected result.
  task automatic load(input int a, input int b, input int s, input int w, input int mode,
                      output int exp_cnt, output int exp_ov);
    int weff;
    int rises;
    bit lvl;
    bit t;
    weff  = (w == 0) ? 1 : w;
    rises = 0;
    lvl   = 1'b0;
    tog_q.delete();
    for (int i = 0; i < weff; i++) begin
      case (mode)
        0:       t = 1'b0;                      // static low
        1:       t = 1'b1;                      // toggles every cycle (clk/2)
        2:       t = ((i % 2) == 0);            // clk/4 square wave
        default: t = 1'($urandom_range(0, 1));  // irregular ring
      endcase
      tog_q.push_back(t);
      if (t) begin
        lvl = ~lvl;
        if (lvl) rises++;
      end
    end
    a_in    = WIDTH'(a);
    b_in    = WIDTH'(b);
    settle  = 8'(s);
    window  = WIN_W'(w);
    exp_cnt = (rises > CNT_MAX) ? CNT_MAX : rises;
    exp_ov  = (rises > CNT_MAX) ? 1 : 0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!done) check("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic measure(input int a, input int b, input int s, input int w,
                         input int mode, input bit noise);
    int   ec;
    int   eo;
    exp_t e;
    load(a, b, s, w, mode, ec, eo);
    e.t_issue = $time;
    e.lat     = s + ((w == 0) ? 1 : w) + 6;
    e.ren     = (w == 0) ? 1 : w;
    e.a       = a;
    e.b       = b;
    e.cnt     = ec;
    e.ov      = eo;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (noise) begin
      // Starts with new operands while busy must be ignored.
      repeat (3) begin
        @(negedge clk);
        if (busy) begin
          a_in   = WIDTH'($urandom);
          b_in   = WIDTH'($urandom);
          settle = 8'($urandom);
          window = WIN_W'($urandom);
          start  = 1'b1;
          @(negedge clk);
          start  = 1'b0;
        end
      end
    end
    wait_done(400);
  endtask

  initial begin : stimulus
    int ec;
    int eo;
    int n;
    int k;
    int last;
    int passes;
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    cont    = 1'b0;
    ring_in = 1'b0;
    a_in    = '0;
    b_in    = '0;
    settle  = '0;
    window  = '0;

    // Reset with every input toggling: outputs must all read zero.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("reset_outputs",
            int'({adder_a, adder_b, ring_en, count, overflow, busy, done}), 0);
      {start, abort, cont, ring_in} = 4'($urandom);
      a_in   = WIDTH'($urandom);
      b_in   = WIDTH'($urandom);
      settle = 8'($urandom);
      window = WIN_W'($urandom);
    end
    @(negedge clk);
    rst       = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    cont      = 1'b0;
    ring_in   = 1'b0;
    ring_auto = 1'b1;
    @(negedge clk);
    check("idle_busy_after_reset", int'(busy), 0);
    check("idle_done_after_reset", int'(done), 0);

    // clk/4 ring, 100-cycle window: 25 rising edges, done in cycle 108.
    measure(8'h5A, 8'hA5, 2, 100, 2, 1'b0);
    // Zero window and settle with a silent ring: one enabled cycle, zero count.
    measure(8'h01, 8'h02, 0, 0, 0, 1'b0);
    // Ring at clk/2 for 100 cycles saturates the narrow counter.
    measure(8'h33, 8'hCC, 1, 100, 1, 1'b0);

    // Abort in the 10th RUN cycle: clk/4 ring leaves two counted edges.
    load(8'h11, 8'h22, 3, 50, 2, ec, eo);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    k = 0;
    while (n < 10 && k < 200) begin
      @(negedge clk);
      k++;
      if (ring_en) n++;
    end
    check("abort_reached_run", n, 10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ring_en", int'(ring_en), 0);
    check("abort_busy",    int'(busy), 0);
    check("abort_done",    int'(done), 0);
    check("abort_count",   int'(count), 2);
    check("abort_adder_a", int'(adder_a), 8'h11);
    repeat (3) @(negedge clk);
    check("abort_count_frozen", int'(count), 2);
    check("abort_stays_idle",   int'(busy), 0);

    // Start and abort together in IDLE: nothing starts, operands hold.
    a_in  = 8'hEE;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy",    int'(busy), 0);
    check("start_abort_adder_a", int'(adder_a), 8'h11);
    @(negedge clk);
    check("start_abort_still_idle", int'(busy), 0);

    // A fresh measurement after abort counts from zero (clk/4, 20 cycles -> 5).
    measure(8'h77, 8'h88, 1, 20, 2, 1'b0);

    // Randomized measurements with ignored starts sprinkled in.
    for (int i = 0; i < 12; i++) begin
      measure(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 6)), int'($urandom_range(0, 70)),
              int'($urandom_range(0, 3)), 1'b1);
    end

`ifdef CONTINUOUS_EN
    // Back-to-back passes: done pulses every 16 cycles, operands re-latched.
    cont_mode = 1'b1;
    cont      = 1'b1;
    load(8'h40, 8'h01, 1, 10, 0, ec, eo);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    last   = -1;
    passes = 0;
    k      = 0;
    while (passes < 4 && k < 200) begin
      @(negedge clk);
      k++;
      if (done) begin
        if (last >= 0) check("cont_period", k - last, 16);
        check("cont_busy_in_done", int'(busy), 0);
        last = k;
        passes++;
        a_in = a_in + 8'h01;
        if (passes == 4) cont = 1'b0;
        @(negedge clk);
        k++;
        if (passes < 4) begin
          check("cont_done_pulse", int'(done), 0);
          check("cont_busy_again", int'(busy), 1);
          check("cont_adder_a",    int'(adder_a), int'(a_in));
        end
      end
    end
    check("cont_passes", passes, 4);
    repeat (2) @(negedge clk);
    cont_mode = 1'b0;
`else
    // cont is ignored: DONE returns to IDLE and done stays sticky.
    cont = 1'b1;
    measure(8'h10, 8'h20, 1, 5, 3, 1'b0);
    check("no_cont_idle", int'(busy), 0);
    check("no_cont_done_sticky", int'(done), 1);
    repeat (3) @(negedge clk);
    check("no_cont_no_retrigger", int'(busy), 0);
    cont = 1'b0;
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
